// File: rtl/mmio_store_buffer_if.sv
// CPU data-port and drain-side handshake bundle for mmio_store_buffer.
// master = CPU/consumer side, slave = the store buffer itself.
interface mmio_store_buffer_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Out_valid;
  logic [31:0] Out_data;
  logic        Out_ready;
  logic [31:0] Out_stamp;

  modport master (
    output MemWrite, DataAdr, WriteData, Out_ready,
    input  ReadData, Out_valid, Out_data, Out_stamp
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, Out_ready,
    output ReadData, Out_valid, Out_data, Out_stamp
  );
endinterface

// File: rtl/mmio_store_buffer.sv
// MMIO store-capture FIFO: CPU stores to BASE_ADDR are queued and drained over valid/ready.
// Optional per-entry cycle stamp when MMIO_BUF_TIMESTAMP_EN is defined.
module mmio_store_buffer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 8
) (
  input logic                CLK,
  input logic                RESET,
  mmio_store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [31:0]   data_mem [DEPTH];

  logic hit_data;
  logic hit_ctrl;
  logic hit_status;
  logic flush;
  logic ovf_clr;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [7:0] count_byte;

  assign hit_data   = bus.MemWrite && (bus.DataAdr == BASE_ADDR);
  assign hit_ctrl   = bus.MemWrite && (bus.DataAdr == BASE_ADDR + 32'd8);
  assign hit_status = (bus.DataAdr == BASE_ADDR + 32'd4);
  assign flush      = hit_ctrl && bus.WriteData[0];
  assign ovf_clr    = hit_ctrl && bus.WriteData[1];

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && bus.Out_ready;
  // A full FIFO still takes a store when the head leaves in the same cycle.
  assign push  = hit_data && (!full || pop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                  ovf <= 1'b0;
    else if (ovf_clr)           ovf <= 1'b0;
    else if (hit_data && !push) ovf <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) data_mem[wr_ptr] <= bus.WriteData;
  end

  assign bus.Out_valid = !empty;
  // Gated so stale storage never leaks out after reset or flush.
  assign bus.Out_data  = empty ? 32'h0 : data_mem[rd_ptr];

  assign count_byte   = 8'(count);
  assign bus.ReadData = hit_status ? {16'h0, ovf, full, empty, 5'b0, count_byte} : 32'h0;

`ifdef MMIO_BUF_TIMESTAMP_EN
  logic [31:0] stamp_cnt;
  logic [31:0] stamp_mem [DEPTH];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) stamp_cnt <= 32'h0;
    else       stamp_cnt <= stamp_cnt + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) stamp_mem[wr_ptr] <= stamp_cnt;
  end

  assign bus.Out_stamp = empty ? 32'h0 : stamp_mem[rd_ptr];
`else
  assign bus.Out_stamp = 32'h0;
`endif

endmodule
